control_unit_fsm: RTL and testbench

//  Moore FSM that sequences fetch, decode and execute for the basic ARM-subset RISC datapath.

---
 rtl/control_unit_fsm_if.sv | 38 +++
 rtl/control_unit_fsm.sv | 220 ++++++++++++++++++++++
 tb/tb_control_unit_fsm.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/control_unit_fsm_if.sv
// control_unit_fsm_if: bundle between the control unit and the ARM-subset datapath/memory.
// Latency: none, wires only; the control unit drives the strobes, the datapath drives IR/MOC/cond.
// Backpressure: MOC is the only stall input; strobes are level signals valid for a whole state.
interface control_unit_fsm_if;
  // datapath -> control unit
  logic        MOC;
  logic        cond;
  logic [31:0] ir;
  // control unit -> datapath
  logic        FRld;
  logic        RFld;
  logic        IRld;
  logic        MARld;
  logic        MDRld;
  logic        RW;
  logic        MOV;
  logic        Cin;
  logic        MD;
  logic        ME;
  logic [1:0]  MA;
  logic [1:0]  MB;
  logic [1:0]  MC;
  logic [1:0]  DL;
  logic [4:0]  OP;
  logic [9:0]  current_state;

  modport master (
    input  MOC, cond, ir,
    output FRld, RFld, IRld, MARld, MDRld, RW, MOV, Cin, MD, ME,
    output MA, MB, MC, DL, OP, current_state
  );

  modport slave (
    output MOC, cond, ir,
    input  FRld, RFld, IRld, MARld, MDRld, RW, MOV, Cin, MD, ME,
    input  MA, MB, MC, DL, OP, current_state
  );
endinterface

// File: rtl/control_unit_fsm.sv
// control_unit_fsm: Moore fetch/decode/execute sequencer for the ARM-subset datapath (optional macro CU_COND_CHECK_EN).
// Latency: one state per clk; outputs are registered from the next-state decode so they line up with current_state.
// Backpressure: states 3 (fetch) and 41 (store) hold while MOC=0; reset low aborts at once with all outputs 0.
module control_unit_fsm (
  input logic                clk,
  input logic                reset,
  control_unit_fsm_if.master cu
);

  typedef enum logic [9:0] {
    S_RESET      = 10'd0,
    S_FETCH_MAR  = 10'd1,
    S_FETCH_REQ  = 10'd2,
    S_FETCH_WAIT = 10'd3,
    S_DECODE     = 10'd4,
    S_DP_IMM_S   = 10'd10,
    S_DP_IMM     = 10'd11,
    S_B          = 10'd12,
    S_BL         = 10'd13,
    S_OFS_IU     = 10'd20,
    S_OFS_RU     = 10'd21,
    S_PRE_IU     = 10'd22,
    S_PRE_RU     = 10'd23,
    S_POST_IU    = 10'd24,
    S_POST_IU_WB = 10'd25,
    S_POST_RU    = 10'd27,
    S_POST_RU_WB = 10'd28,
    S_OFS_ID     = 10'd30,
    S_OFS_RD     = 10'd31,
    S_PRE_ID     = 10'd32,
    S_PRE_RD     = 10'd33,
    S_POST_ID    = 10'd34,
    S_POST_ID_WB = 10'd35,
    S_POST_RD    = 10'd37,
    S_POST_RD_WB = 10'd38,
    S_STB_MDR    = 10'd40,
    S_STB_WAIT   = 10'd41
  } state_e;

  typedef struct packed {
    logic       fr_ld;
    logic       rf_ld;
    logic       ir_ld;
    logic       mar_ld;
    logic       mdr_ld;
    logic       rw;
    logic       mov;
    logic       me;
    logic       md;
    logic       cin;
    logic [1:0] ma;
    logic [1:0] mb;
    logic [1:0] mc;
    logic [1:0] dl;
    logic [4:0] op;
  } ctl_t;

  localparam logic [4:0] OP_ADD   = 5'b00100;
  localparam logic [4:0] OP_SUB   = 5'b00010;
  localparam logic [4:0] OP_PASSA = 5'b10000;

  state_e state_q, state_d;
  state_e decode_nxt;
  state_e mem_nxt;
  ctl_t   ctl_q, ctl_d;
  logic   exec_ok;
  logic   is_reg;
  logic   stb_byte;
  logic   unused_ir;

  // With condition checking enabled a failed condition skips straight back to fetch.
`ifdef CU_COND_CHECK_EN
  assign exec_ok   = cu.cond;
  assign unused_ir = &{1'b0, cu.ir[31:28], cu.ir[19:5], cu.ir[3:0]};
`else
  assign exec_ok   = 1'b1;
  assign unused_ir = &{1'b0, cu.cond, cu.ir[31:28], cu.ir[19:5], cu.ir[3:0]};
`endif

  // Only store-byte (L=0, B=1) is supported among the single data transfers.
  assign is_reg   = cu.ir[25];
  assign stb_byte = !cu.ir[20] && cu.ir[22];

  // Addressing-mode selection for store byte: {reg offset, U} picks the family, P/W pick offset/pre/post.
  always_comb begin
    mem_nxt = S_FETCH_MAR;
    case ({is_reg, cu.ir[23]})
      2'b01:   mem_nxt = !cu.ir[24] ? S_POST_IU : (cu.ir[21] ? S_PRE_IU : S_OFS_IU);
      2'b00:   mem_nxt = !cu.ir[24] ? S_POST_ID : (cu.ir[21] ? S_PRE_ID : S_OFS_ID);
      2'b11:   mem_nxt = !cu.ir[24] ? S_POST_RU : (cu.ir[21] ? S_PRE_RU : S_OFS_RU);
      default: mem_nxt = !cu.ir[24] ? S_POST_RD : (cu.ir[21] ? S_PRE_RD : S_OFS_RD);
    endcase
  end

  // Instruction class decode from IR[27:25]; anything unsupported returns to fetch.
  always_comb begin
    decode_nxt = S_FETCH_MAR;
    if (exec_ok) begin
      case (cu.ir[27:25])
        3'b001:  decode_nxt = cu.ir[20] ? S_DP_IMM_S : S_DP_IMM;
        3'b101:  decode_nxt = cu.ir[24] ? S_BL : S_B;
        3'b010:  if (stb_byte) decode_nxt = mem_nxt;
        3'b011:  if (stb_byte && !cu.ir[4]) decode_nxt = mem_nxt;
        default: decode_nxt = S_FETCH_MAR;
      endcase
    end
  end

  // Next-state sequencing; unknown codes fall back to reset.
  always_comb begin
    state_d = S_RESET;
    case (state_q)
      S_RESET:      state_d = S_FETCH_MAR;
      S_FETCH_MAR:  state_d = S_FETCH_REQ;
      S_FETCH_REQ:  state_d = S_FETCH_WAIT;
      S_FETCH_WAIT: state_d = cu.MOC ? S_DECODE : S_FETCH_WAIT;
      S_DECODE:     state_d = decode_nxt;
      S_DP_IMM_S,
      S_DP_IMM,
      S_B:          state_d = S_FETCH_MAR;
      S_BL:         state_d = S_B;
      S_OFS_IU, S_OFS_RU, S_OFS_ID, S_OFS_RD,
      S_PRE_IU, S_PRE_RU, S_PRE_ID, S_PRE_RD,
      S_POST_IU_WB, S_POST_RU_WB,
      S_POST_ID_WB, S_POST_RD_WB: state_d = S_STB_MDR;
      S_POST_IU:    state_d = S_POST_IU_WB;
      S_POST_RU:    state_d = S_POST_RU_WB;
      S_POST_ID:    state_d = S_POST_ID_WB;
      S_POST_RD:    state_d = S_POST_RD_WB;
      S_STB_MDR:    state_d = S_STB_WAIT;
      S_STB_WAIT:   state_d = cu.MOC ? S_FETCH_MAR : S_STB_WAIT;
      default:      state_d = S_RESET;
    endcase
  end

  // Moore output decode of the state being entered, so the registered outputs match current_state.
  always_comb begin
    ctl_d = '0;
    case (state_d)
      S_FETCH_MAR: begin
        ctl_d.ma = 2'b01; ctl_d.op = OP_PASSA; ctl_d.mar_ld = 1'b1;
      end
      S_FETCH_REQ: begin
        ctl_d.ma = 2'b01; ctl_d.mb = 2'b10; ctl_d.op = OP_ADD; ctl_d.mc = 2'b10;
        ctl_d.rf_ld = 1'b1; ctl_d.mov = 1'b1; ctl_d.me = 1'b1; ctl_d.rw = 1'b1; ctl_d.dl = 2'b10;
      end
      S_FETCH_WAIT: begin
        ctl_d.mov = 1'b1; ctl_d.me = 1'b1; ctl_d.rw = 1'b1; ctl_d.dl = 2'b10; ctl_d.ir_ld = 1'b1;
      end
      S_DP_IMM_S, S_DP_IMM: begin
        ctl_d.mb = 2'b01; ctl_d.op = {1'b0, cu.ir[24:21]}; ctl_d.rf_ld = 1'b1;
        ctl_d.fr_ld = (state_d == S_DP_IMM_S);
      end
      S_BL: begin
        ctl_d.ma = 2'b01; ctl_d.op = OP_PASSA; ctl_d.mc = 2'b01; ctl_d.rf_ld = 1'b1;
      end
      S_B: begin
        ctl_d.ma = 2'b01; ctl_d.mb = 2'b11; ctl_d.op = OP_ADD; ctl_d.mc = 2'b10; ctl_d.rf_ld = 1'b1;
      end
      S_OFS_IU, S_OFS_ID, S_PRE_IU, S_PRE_ID: begin
        ctl_d.mb = 2'b01; ctl_d.mar_ld = 1'b1;
        ctl_d.op = (state_d == S_OFS_IU || state_d == S_PRE_IU) ? OP_ADD : OP_SUB;
        if (state_d == S_PRE_IU || state_d == S_PRE_ID) begin
          ctl_d.mc = 2'b11; ctl_d.rf_ld = 1'b1;
        end
      end
      S_OFS_RU, S_OFS_RD, S_PRE_RU, S_PRE_RD: begin
        ctl_d.mb = 2'b00; ctl_d.mar_ld = 1'b1;
        ctl_d.op = (state_d == S_OFS_RU || state_d == S_PRE_RU) ? OP_ADD : OP_SUB;
        if (state_d == S_PRE_RU || state_d == S_PRE_RD) begin
          ctl_d.mc = 2'b11; ctl_d.rf_ld = 1'b1;
        end
      end
      S_POST_IU, S_POST_RU, S_POST_ID, S_POST_RD: begin
        ctl_d.op = OP_PASSA; ctl_d.mar_ld = 1'b1;
      end
      S_POST_IU_WB, S_POST_RU_WB, S_POST_ID_WB, S_POST_RD_WB: begin
        ctl_d.mc = 2'b11; ctl_d.rf_ld = 1'b1;
        ctl_d.mb = (state_d == S_POST_IU_WB || state_d == S_POST_ID_WB) ? 2'b01 : 2'b00;
        ctl_d.op = (state_d == S_POST_IU_WB || state_d == S_POST_RU_WB) ? OP_ADD : OP_SUB;
      end
      S_STB_MDR: begin
        ctl_d.ma = 2'b10; ctl_d.op = OP_PASSA; ctl_d.md = 1'b1; ctl_d.mdr_ld = 1'b1;
      end
      S_STB_WAIT: begin
        ctl_d.mov = 1'b1; ctl_d.me = 1'b1; ctl_d.rw = 1'b0; ctl_d.dl = 2'b00;
      end
      default: ctl_d = '0;
    endcase
  end

  // State and output registers; reset clears both immediately, dropping any memory request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_RESET;
      ctl_q   <= '0;
    end else begin
      state_q <= state_d;
      ctl_q   <= ctl_d;
    end
  end

  assign cu.FRld          = ctl_q.fr_ld;
  assign cu.RFld          = ctl_q.rf_ld;
  assign cu.IRld          = ctl_q.ir_ld;
  assign cu.MARld         = ctl_q.mar_ld;
  assign cu.MDRld         = ctl_q.mdr_ld;
  assign cu.RW            = ctl_q.rw;
  assign cu.MOV           = ctl_q.mov;
  assign cu.ME            = ctl_q.me;
  assign cu.MD            = ctl_q.md;
  assign cu.Cin           = ctl_q.cin;
  assign cu.MA            = ctl_q.ma;
  assign cu.MB            = ctl_q.mb;
  assign cu.MC            = ctl_q.mc;
  assign cu.DL            = ctl_q.dl;
  assign cu.OP            = ctl_q.op;
  assign cu.current_state = state_q;

endmodule

// File: tb/tb_control_unit_fsm.sv
// tb_control_unit_fsm: table-driven check of fetch/decode/execute sequences plus stall, abort and cond cases.
// Latency: one table row per clock, compared 1 time unit after the rising edge.
// Backpressure: MOC is driven per row; MOC=0 rows exercise the stall states.
module tb_control_unit_fsm;

  typedef struct {
    logic [31:0] ir;
    logic        moc;
    logic [9:0]  st;
    logic [22:0] ctl;  // {FRld,RFld,IRld,MARld,MDRld,RW,MOV,ME,MD,Cin,MA,MB,MC,DL,OP}
  } vec_t;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_fail;
  vec_t vecs[$];

  control_unit_fsm_if cu_if ();

  control_unit_fsm dut (
    .clk   (clk),
    .reset (reset),
    .cu    (cu_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [22:0] act_ctl();
    return {cu_if.FRld, cu_if.RFld, cu_if.IRld, cu_if.MARld, cu_if.MDRld,
            cu_if.RW, cu_if.MOV, cu_if.ME, cu_if.MD, cu_if.Cin,
            cu_if.MA, cu_if.MB, cu_if.MC, cu_if.DL, cu_if.OP};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // bits = {FRld,RFld,IRld,MARld,MDRld,RW,MOV,ME,MD,Cin}
  task automatic add(input logic [31:0] ir, input logic moc, input int st, input logic [9:0] bits,
                     input logic [1:0] ma, input logic [1:0] mb, input logic [1:0] mc,
                     input logic [1:0] dl, input logic [4:0] op);
    vec_t v;
    v.ir  = ir;
    v.moc = moc;
    v.st  = st[9:0];
    v.ctl = {bits, ma, mb, mc, dl, op};
    vecs.push_back(v);
  endtask

  // Fetch rows 1,2,3 (+ holds in 3 with MOC=0), then 4.
  task automatic add_fetch(input logic [31:0] ir, input int holds);
    add(ir, 1'b1, 1, 10'b0001000000, 2'b01, 2'b00, 2'b00, 2'b00, 5'b10000);
    add(ir, 1'b1, 2, 10'b0100011100, 2'b01, 2'b10, 2'b10, 2'b10, 5'b00100);
    add(ir, 1'b1, 3, 10'b0010011100, 2'b00, 2'b00, 2'b00, 2'b10, 5'b00000);
    for (int h = 0; h < holds; h++)
      add(ir, 1'b0, 3, 10'b0010011100, 2'b00, 2'b00, 2'b00, 2'b10, 5'b00000);
    add(ir, 1'b1, 4, 10'b0000000000, 2'b00, 2'b00, 2'b00, 2'b00, 5'b00000);
  endtask

  // Store-byte tail: 40 then 41 (+ holds with MOC=0).
  task automatic add_store(input logic [31:0] ir, input int holds);
    add(ir, 1'b1, 40, 10'b0000100010, 2'b10, 2'b00, 2'b00, 2'b00, 5'b10000);
    add(ir, 1'b1, 41, 10'b0000001100, 2'b00, 2'b00, 2'b00, 2'b00, 5'b00000);
    for (int h = 0; h < holds; h++)
      add(ir, 1'b0, 41, 10'b0000001100, 2'b00, 2'b00, 2'b00, 2'b00, 5'b00000);
  endtask

  initial begin
    bit seen;
    n_chk  = 0;
    n_fail = 0;
    reset  = 1'b1;
    cu_if.MOC  = 1'b0;
    cu_if.cond = 1'b1;
    cu_if.ir   = 32'h0;

    // data processing immediate, S=0, opcode AND
    add_fetch(32'hE2001028, 0);
    add(32'hE2001028, 1'b1, 11, 10'b0100000000, 2'b00, 2'b01, 2'b00, 2'b00, 5'b00000);
    // S=1 -> flags loaded
    add_fetch(32'hE2101028, 0);
    add(32'hE2101028, 1'b1, 10, 10'b1100000000, 2'b00, 2'b01, 2'b00, 2'b00, 5'b00000);
    // ADD opcode, with two stall cycles in fetch
    add_fetch(32'hE2801028, 2);
    add(32'hE2801028, 1'b1, 11, 10'b0100000000, 2'b00, 2'b01, 2'b00, 2'b00, 5'b00100);
    // branch
    add_fetch(32'h0A000000, 0);
    add(32'h0A000000, 1'b1, 12, 10'b0100000000, 2'b01, 2'b11, 2'b10, 2'b00, 5'b00100);
    // branch and link
    add_fetch(32'h0B000000, 0);
    add(32'h0B000000, 1'b1, 13, 10'b0100000000, 2'b01, 2'b00, 2'b01, 2'b00, 5'b10000);
    add(32'h0B000000, 1'b1, 12, 10'b0100000000, 2'b01, 2'b11, 2'b10, 2'b00, 5'b00100);
    // STRB imm offset, U=1, with two stall cycles in 41
    add_fetch(32'hE5C12001, 0);
    add(32'hE5C12001, 1'b1, 20, 10'b0001000000, 2'b00, 2'b01, 2'b00, 2'b00, 5'b00100);
    add_store(32'hE5C12001, 2);
    // STRB imm post-indexed, U=0
    add_fetch(32'hE4412001, 0);
    add(32'hE4412001, 1'b1, 34, 10'b0001000000, 2'b00, 2'b00, 2'b00, 2'b00, 5'b10000);
    add(32'hE4412001, 1'b1, 35, 10'b0100000000, 2'b00, 2'b01, 2'b11, 2'b00, 5'b00010);
    add_store(32'hE4412001, 0);
    // STRB reg post-indexed, U=0
    add_fetch(32'hE6412003, 0);
    add(32'hE6412003, 1'b1, 37, 10'b0001000000, 2'b00, 2'b00, 2'b00, 2'b00, 5'b10000);
    add(32'hE6412003, 1'b1, 38, 10'b0100000000, 2'b00, 2'b00, 2'b11, 2'b00, 5'b00010);
    add_store(32'hE6412003, 0);
    // STRB imm pre-indexed with writeback, U=1
    add_fetch(32'hE5E12001, 0);
    add(32'hE5E12001, 1'b1, 22, 10'b0101000000, 2'b00, 2'b01, 2'b11, 2'b00, 5'b00100);
    add_store(32'hE5E12001, 0);
    // unsupported: register data-proc, then load byte -> straight back to fetch
    add_fetch(32'hE0812003, 0);
    add_fetch(32'hE5D12001, 0);
    add(32'hE5D12001, 1'b1, 1, 10'b0001000000, 2'b01, 2'b00, 2'b00, 2'b00, 5'b10000);

    // reset state
    #2 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", {22'd0, cu_if.current_state}, 32'd0);
    chk("reset_outputs", {9'd0, act_ctl()}, 32'd0);

    @(negedge clk);
    reset = 1'b1;
    foreach (vecs[i]) begin
      cu_if.ir  = vecs[i].ir;
      cu_if.MOC = vecs[i].moc;
      @(posedge clk);
      #1;
      chk($sformatf("row%0d_state", i), {22'd0, cu_if.current_state}, {22'd0, vecs[i].st});
      chk($sformatf("row%0d_outputs", i), {9'd0, act_ctl()}, {9'd0, vecs[i].ctl});
      @(negedge clk);
    end

    // reset in the middle of a store access aborts the request immediately
    cu_if.ir  = 32'hE5C12001;
    cu_if.MOC = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(posedge clk);
      #1;
      if (cu_if.current_state == 10'd41) seen = 1'b1;
    end
    chk("reach_41_in_budget", {31'd0, seen}, 32'd1);
    cu_if.MOC = 1'b0;
    @(posedge clk);
    #1;
    chk("hold_41_state", {22'd0, cu_if.current_state}, 32'd41);
    chk("hold_41_mov", {31'd0, cu_if.MOV}, 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("abort_state", {22'd0, cu_if.current_state}, 32'd0);
    chk("abort_mov_me", {30'd0, cu_if.MOV, cu_if.ME}, 32'd0);

    // cond=0 at decode
    @(negedge clk);
    reset      = 1'b1;
    cu_if.MOC  = 1'b1;
    cu_if.cond = 1'b0;
    cu_if.ir   = 32'hE2801028;
    repeat (4) @(posedge clk);
    #1;
    chk("cond_decode_state", {22'd0, cu_if.current_state}, 32'd4);
    @(posedge clk);
    #1;
`ifdef CU_COND_CHECK_EN
    chk("cond_fail_to_fetch", {22'd0, cu_if.current_state}, 32'd1);
    chk("cond_fail_no_rfld", {31'd0, cu_if.RFld}, 32'd0);
`else
    chk("cond_ignored_state", {22'd0, cu_if.current_state}, 32'd11);
    chk("cond_ignored_op", {27'd0, cu_if.OP}, 32'd4);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
